// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN / ILEN   : address and instruction widths
//   RESET_VECTOR  : default first fetch address after reset
//   NOP           : canonical RISC-V no-op (addi x0, x0, 0)
//   PC_STEP       : sequential fetch increment
//   word_align()  : clears the two low address bits
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP          = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req_valid/ready/addr : fetch request channel (fetch -> memory)
//   imem_rsp_valid/data       : in-order response channel, no backpressure
//   if_valid/ready/pc/instr   : fetched instruction towards decode
// Handshake rule for both valid/ready channels: a transfer happens in a cycle
// where valid and ready are both high; the sender keeps payload stable while
// valid is high and ready is low. The response channel has no ready and
// every valid cycle is a transfer.
// Modports: master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO used for the response buffer and the address tag queue.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push/push_data : write an entry (ignored when full unless popping too)
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; overrides push and pop in the same cycle
//   head_data   : oldest entry, valid while !empty
//   count/empty/full : occupancy status
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed behind count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order requests to instruction memory,
// buffers responses and presents {pc, instr} to decode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   redirect_valid : one-cycle EX redirect; younger fetches are discarded
//   redirect_pc    : redirect target (low two bits ignored)
//   bus (master)   : imem request/response channels and the decode channel
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (buffer entries and
// the total number of credits shared by in-flight and buffered fetches).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BUF_W = XLEN + ILEN;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W:0]   credits_used;
    logic             req_fire;
    logic             rsp_keep;
    logic             pop_fire;

    logic [BUF_W-1:0] buf_head;
    logic [CNT_W-1:0] buf_count, tag_count;
    logic             buf_empty, buf_full;
    logic [XLEN-1:0]  tag_head;
    logic             tag_empty, tag_full;
    logic             unused_fifo_status;

    // Every request reserves a buffer slot until its entry is popped, so the
    // response buffer and the tag queue can never overflow.
    assign credits_used       = {1'b0, inflight_q} + {1'b0, buf_count};
    assign bus.imem_req_valid = rst_n && !redirect_valid
                                && (credits_used < (CNT_W+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Responses belonging to fetches issued before a redirect are dropped:
    // those still counted in discard_q, and the one arriving in the redirect
    // cycle itself.
    assign rsp_keep = bus.imem_rsp_valid && !redirect_valid && (discard_q == '0);

    assign bus.if_valid = !buf_empty;
    assign bus.if_pc    = buf_head[BUF_W-1 -: XLEN];
    assign bus.if_instr = buf_empty ? NOP : buf_head[ILEN-1:0];
    assign pop_fire     = !buf_empty && bus.if_ready;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;

        if (req_fire) pc_d = pc_q + PC_STEP;

        // The in-flight count tracks every issued request until its response
        // returns, whether that response is kept or discarded.
        case ({req_fire, bus.imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (redirect_valid) begin
            pc_d      = word_align(redirect_pc);
            discard_d = inflight_q - CNT_W'(bus.imem_rsp_valid);
        end else if (bus.imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Addresses of live (non-discarded) requests, oldest first; the head
    // tags the next kept response.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head_data (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // {pc, instr} entries waiting for decode. A pop in a redirect cycle is
    // still a completed handshake; the flush only removes what remains.
    fetch_fifo #(.WIDTH(BUF_W), .DEPTH(FIFO_DEPTH)) u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data ({tag_head, bus.imem_rsp_data}),
        .pop       (pop_fire),
        .flush     (redirect_valid),
        .head_data (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign unused_fifo_status = &{1'b0, buf_full, tag_full, tag_empty, tag_count};

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH       = 2;
    localparam logic [31:0] DATA_KEY    = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    // ---------------- memory model ----------------
    // Fixed-latency in-order memory: a request accepted in cycle c returns
    // addr ^ DATA_KEY in cycle c + mem_lat. Latency only changes while idle.
    int          mem_lat = 1;
    int          mem_due_q[$];
    logic [31:0] mem_data_q[$];

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
                mem_due_q.push_back(cyc + mem_lat);
                mem_data_q.push_back(bus.imem_req_addr ^ DATA_KEY);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_due_q.delete();
                mem_data_q.delete();
            end
            if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_data_q.pop_front();
                void'(mem_due_q.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Reference: the decode stream is the sequential word stream starting at
    // RESET_PC, restarted at the aligned target after each redirect; each
    // instruction equals its pc ^ DATA_KEY. Request addresses follow the same
    // rule. exp_q holds the next expected stream pcs (head = next pop).
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic        after_redirect;
    int          n_pop = 0;
    int          n_acc = 0;

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back(start);
        exp_addr = start;
    endtask

    task automatic settle();
        logic [31:0] want;
        @(negedge clk);
        if (!rst_n) begin
            restart_stream(TB_RESET_PC);
            after_redirect = 1'b0;
            tests_run++;
            if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: if_valid=%b req_valid=%b, required 0 and 0",
                         bus.if_valid, bus.imem_req_valid);
            end
        end else begin
            if (after_redirect) begin
                tests_run++;
                if (bus.if_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL if_valid_after_redirect: got %b, required 0", bus.if_valid);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                tests_run++;
                if (bus.imem_req_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL req_addr: got %h, required %h", bus.imem_req_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
                n_acc++;
            end
            if (bus.if_valid && bus.if_ready) begin
                want = exp_q.pop_front();
                tests_run++;
                if (bus.if_pc !== want || bus.if_instr !== (want ^ DATA_KEY)) begin
                    tests_failed++;
                    $display("FAIL pop_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.if_pc, bus.if_instr, want, want ^ DATA_KEY);
                end
                exp_q.push_back(want + 32'd4);
                n_pop++;
            end
            if (redirect_valid) begin
                tests_run++;
                if (bus.imem_req_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL req_in_redirect: req_valid=%b, required 0", bus.imem_req_valid);
                end
                restart_stream(redirect_pc & 32'hFFFF_FFFC);
            end
            after_redirect = redirect_valid;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic quiesce();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b1;
        repeat (10) cycle();
    endtask

    // Runs with current inputs until decode has taken `count` more entries.
    task automatic run_pops(input int count, input int budget, input string name);
        int target;
        target = n_pop + count;
        for (int k = 0; k < budget && n_pop < target; k++) cycle();
        tests_run++;
        if (n_pop < target) begin
            tests_failed++;
            $display("FAIL %s_progress: %0d pops, required %0d within %0d cycles",
                     name, n_pop - (target - count), count, budget);
        end
    endtask

    // Waits for the first entry offered to decode and checks its pc.
    task automatic expect_first_pc(input logic [31:0] want, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            settle();
            if (bus.if_valid === 1'b1) begin
                got = 1'b1;
                tests_run++;
                if (bus.if_pc !== want) begin
                    tests_failed++;
                    $display("FAIL %s: first if_pc=%h, required %h", name, bus.if_pc, want);
                end
            end
            advance();
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s_timeout: if_valid never rose, required within 20 cycles", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        repeat (3) begin
            settle();
            tests_run++;
            if (bus.imem_req_addr !== TB_RESET_PC) begin
                tests_failed++;
                $display("FAIL reset_addr: got %h, required %h", bus.imem_req_addr, TB_RESET_PC);
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        mem_lat = 1;
        settle();
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== TB_RESET_PC) begin
            tests_failed++;
            $display("FAIL first_req: valid=%b addr=%h, required 1 and %h",
                     bus.imem_req_valid, bus.imem_req_addr, TB_RESET_PC);
        end
        tests_run++;
        if (bus.if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_bypass_t0: if_valid=%b, required 0", bus.if_valid);
        end
        advance();
        settle();
        tests_run++;
        if (bus.if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_bypass_t1: if_valid=%b, required 0", bus.if_valid);
        end
        advance();
        settle();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== TB_RESET_PC
            || bus.if_instr !== (TB_RESET_PC ^ DATA_KEY)) begin
            tests_failed++;
            $display("FAIL first_out_t2: valid=%b pc=%h instr=%h, required 1 %h %h",
                     bus.if_valid, bus.if_pc, bus.if_instr, TB_RESET_PC, TB_RESET_PC ^ DATA_KEY);
        end
        advance();
        run_pops(12, 60, "stream");
    endtask

    task automatic test_stall();
        int acc0;
        acc0         = n_acc;
        bus.if_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (k >= 2) begin
                tests_run++;
                if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL stall_hold: valid=%b pc=%h, required 1 %h",
                             bus.if_valid, bus.if_pc, exp_q[0]);
                end
                tests_run++;
                if (bus.imem_req_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_no_req: req_valid=%b, required 0", bus.imem_req_valid);
                end
            end
            advance();
        end
        tests_run++;
        if (n_acc - acc0 > DEPTH) begin
            tests_failed++;
            $display("FAIL stall_credits: %0d accepted, required at most %0d", n_acc - acc0, DEPTH);
        end
        bus.if_ready = 1'b1;
        run_pops(8, 40, "stall_release");
    endtask

    task automatic test_redirect_inflight();
        int acc0;
        quiesce();
        mem_lat            = 3;
        acc0               = n_acc;
        bus.imem_req_ready = 1'b1;
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0104;
        settle();
        tests_run++;
        if (n_acc - acc0 != 2) begin
            tests_failed++;
            $display("FAIL two_in_flight: %0d accepted, required 2", n_acc - acc0);
        end
        advance();
        redirect_valid = 1'b0;
        settle();
        tests_run++;
        if (bus.imem_req_addr !== 32'h0000_0104) begin
            tests_failed++;
            $display("FAIL redirect_addr: got %h, required 00000104", bus.imem_req_addr);
        end
        advance();
        expect_first_pc(32'h0000_0104, "redirect_inflight_pc");
        run_pops(4, 40, "redirect_inflight");
    endtask

    task automatic test_redirect_collide();
        logic [31:0] a;
        logic [31:0] tgt;
        quiesce();
        mem_lat            = 1;
        bus.if_ready       = 1'b0;
        bus.imem_req_ready = 1'b1;
        a = exp_addr;
        cycle();
        cycle();
        tgt            = $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        bus.if_ready   = 1'b1;
        settle();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== a || bus.imem_rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL collide_setup: valid=%b pc=%h rsp=%b, required 1 %h 1",
                     bus.if_valid, bus.if_pc, bus.imem_rsp_valid, a);
        end
        advance();
        redirect_valid = 1'b0;
        expect_first_pc(tgt & 32'hFFFF_FFFC, "collide_first_pc");
        run_pops(4, 40, "collide");
    endtask

    task automatic test_backpressure();
        quiesce();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            tests_run++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0020) begin
                tests_failed++;
                $display("FAIL bp_hold: valid=%b addr=%h, required 1 00000020",
                         bus.imem_req_valid, bus.imem_req_addr);
            end
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        cycle();
        redirect_valid = 1'b0;
        settle();
        tests_run++;
        if (bus.imem_req_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL redirect_mask: addr=%h, required 00000100", bus.imem_req_addr);
        end
        advance();
        bus.imem_req_ready = 1'b1;
        expect_first_pc(32'h0000_0100, "bp_first_pc");
    endtask

    task automatic test_random();
        for (int lat = 1; lat <= 3; lat++) begin
            quiesce();
            mem_lat = lat;
            for (int k = 0; k < 150; k++) begin
                bus.if_ready       = ($urandom_range(0, 3) != 0);
                bus.imem_req_ready = ($urandom_range(0, 3) != 0);
                redirect_valid     = ($urandom_range(0, 15) == 0);
                redirect_pc        = $urandom;
                cycle();
            end
            redirect_valid     = 1'b0;
            bus.if_ready       = 1'b1;
            bus.imem_req_ready = 1'b1;
            run_pops(6, 40, "random_drain");
        end
    endtask

    task automatic test_reset_mid();
        quiesce();
        mem_lat            = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;
        repeat (4) cycle();
        settle();
        tests_run++;
        if (bus.if_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_full: if_valid=%b, required 1", bus.if_valid);
        end
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0
            || bus.imem_req_addr !== TB_RESET_PC) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b req=%b addr=%h, required 0 0 %h",
                     bus.if_valid, bus.imem_req_valid, bus.imem_req_addr, TB_RESET_PC);
        end
        settle();
        advance();
        cycle();
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;
        expect_first_pc(TB_RESET_PC, "post_reset_pc");
        run_pops(6, 40, "post_reset");
    endtask

    initial begin
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.imem_req_ready = 1'b0;
        bus.if_ready       = 1'b0;
        after_redirect     = 1'b0;
        restart_stream(TB_RESET_PC);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
